// File: rtl/pc_ras.sv
// pc_ras -- program counter with a circular return-address stack.
//
// Each rising clk edge applies at most one command, chosen by the priority
// ret > call > jmp > sub > add > inc. All pc arithmetic wraps modulo 2^WIDTH.
// A call pushes (pc + STEP). A call on a full stack overwrites the oldest
// entry and sets the sticky ovf flag. A ret on an empty stack leaves pc
// unchanged and sets the sticky unf flag. Both flags are cleared only by
// reset.
//
// Parameters:
//   WIDTH  pc / offset / target width (>= 4)
//   DEPTH  return-address stack entries (power of two, >= 2)
//   STEP   increment used by inc and for the return address
// Ports:
//   clk     sole clock, rising edge
//   reset   synchronous active-low reset
//   inc/add/sub/jmp/call/ret   command strobes
//   offset  unsigned operand for add/sub
//   target  destination for jmp/call
//   pc      registered program counter
//   level   number of valid stack entries, 0..DEPTH
//   empty   level == 0
//   full    level == DEPTH
//   ovf     sticky: a call happened while full
//   unf     sticky: a ret happened while empty
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     add,
  input  logic                     sub,
  input  logic                     jmp,
  input  logic                     call,
  input  logic                     ret,
  input  logic [WIDTH-1:0]         offset,
  input  logic [WIDTH-1:0]         target,
  output logic [WIDTH-1:0]         pc,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_ONE = LW'(1);
  localparam logic [PW-1:0]    SP_ONE  = PW'(1);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_INC  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_JMP  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6
  } op_e;

  logic [WIDTH-1:0] pc_r;
  logic [LW-1:0]    level_r;
  logic             ovf_r;
  logic             unf_r;
  // sp_r points at the slot the next push writes. When the stack is full
  // that slot holds the oldest entry, so a push there gives circular
  // overwrite without extra logic.
  logic [PW-1:0]    sp_r;
  logic [WIDTH-1:0] stack_r [DEPTH];

  op_e              op_s;
  logic [WIDTH-1:0] pc_s;
  logic [LW-1:0]    level_s;
  logic             ovf_s;
  logic             unf_s;
  logic [PW-1:0]    sp_s;
  logic             push_s;
  logic [PW-1:0]    sp_prev_s;
  logic [WIDTH-1:0] ret_addr_s;

  assign sp_prev_s  = sp_r - SP_ONE;
  assign ret_addr_s = pc_r + STEP_W;

  // Priority select of the single winning command.
  always_comb begin
    op_s = OP_NONE;
    if (ret) begin
      op_s = OP_RET;
    end else if (call) begin
      op_s = OP_CALL;
    end else if (jmp) begin
      op_s = OP_JMP;
    end else if (sub) begin
      op_s = OP_SUB;
    end else if (add) begin
      op_s = OP_ADD;
    end else if (inc) begin
      op_s = OP_INC;
    end else begin
      op_s = OP_NONE;
    end
  end

  // Next-state computation for pc, stack pointer, level and sticky flags.
  always_comb begin
    pc_s    = pc_r;
    level_s = level_r;
    ovf_s   = ovf_r;
    unf_s   = unf_r;
    sp_s    = sp_r;
    push_s  = 1'b0;
    case (op_s)
      OP_INC:  pc_s = pc_r + STEP_W;
      OP_ADD:  pc_s = pc_r + offset;
      OP_SUB:  pc_s = pc_r - offset;
      OP_JMP:  pc_s = target;
      OP_CALL: begin
        pc_s   = target;
        push_s = 1'b1;
        sp_s   = sp_r + SP_ONE;
        if (level_r == DEPTH_L) begin
          ovf_s = 1'b1;
        end else begin
          level_s = level_r + LVL_ONE;
        end
      end
      OP_RET: begin
        if (level_r == {LW{1'b0}}) begin
          unf_s = 1'b1;
        end else begin
          pc_s    = stack_r[sp_prev_s];
          sp_s    = sp_prev_s;
          level_s = level_r - LVL_ONE;
        end
      end
      default: begin
        pc_s = pc_r;
      end
    endcase
  end

  // State registers with synchronous active-low reset that also clears the stack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r    <= {WIDTH{1'b0}};
      level_r <= {LW{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      sp_r    <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pc_r    <= pc_s;
      level_r <= level_s;
      ovf_r   <= ovf_s;
      unf_r   <= unf_s;
      sp_r    <= sp_s;
      if (push_s) begin
        stack_r[sp_r] <= ret_addr_s;
      end
    end
  end

  assign pc    = pc_r;
  assign level = level_r;
  assign ovf   = ovf_r;
  assign unf   = unf_r;
  assign empty = (level_r == {LW{1'b0}});
  assign full  = (level_r == DEPTH_L);

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras -- self-checking bench for pc_ras (WIDTH=16, DEPTH=4, STEP=1).
// A queue-based reference model tracks pc, stack and flags. Every cycle
// compares the DUT against it. Table vectors and hand-written sequences add
// fixed expected values on top of that.
module tb_pc_ras;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int STEP  = 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  // command bit positions: {ret, call, jmp, sub, add, inc}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_INC  = 6'b000001;
  localparam logic [5:0] C_ADD  = 6'b000010;
  localparam logic [5:0] C_SUB  = 6'b000100;
  localparam logic [5:0] C_JMP  = 6'b001000;
  localparam logic [5:0] C_CALL = 6'b010000;
  localparam logic [5:0] C_RET  = 6'b100000;

  logic clk = 1'b0;
  logic reset, inc, add, sub, jmp, call, ret;
  logic [WIDTH-1:0] offset, target, pc;
  logic [LW-1:0] level;
  logic empty, full, ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stack[$];
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_ras #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .inc(inc), .add(add), .sub(sub), .jmp(jmp),
    .call(call), .ret(ret), .offset(offset), .target(target), .pc(pc),
    .level(level), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit rst_n, input logic [5:0] c,
                                     input logic [WIDTH-1:0] off,
                                     input logic [WIDTH-1:0] tgt);
    if (!rst_n) begin
      m_pc = '0; m_stack.delete(); m_ovf = 0; m_unf = 0;
    end else if (c[5]) begin
      if (m_stack.size() == 0) m_unf = 1;
      else m_pc = m_stack.pop_back();
    end else if (c[4]) begin
      m_stack.push_back(m_pc + WIDTH'(STEP));
      if (m_stack.size() > DEPTH) begin
        void'(m_stack.pop_front());
        m_ovf = 1;
      end
      m_pc = tgt;
    end else if (c[3]) m_pc = tgt;
    else if (c[2]) m_pc = m_pc - off;
    else if (c[1]) m_pc = m_pc + off;
    else if (c[0]) m_pc = m_pc + WIDTH'(STEP);
  endfunction

  // Apply one cycle of stimulus, advance the model, compare all outputs.
  task automatic drive(input bit rst_n, input logic [5:0] c,
                       input logic [WIDTH-1:0] off, input logic [WIDTH-1:0] tgt);
    reset = rst_n;
    {ret, call, jmp, sub, add, inc} = c;
    offset = off; target = tgt;
    model_step(rst_n, c, off, tgt);
    @(posedge clk);
    #1;
    check("model_pc", int'(pc), int'(m_pc));
    check("model_level", int'(level), m_stack.size());
    check("model_empty", int'(empty), int'(m_stack.size() == 0));
    check("model_full", int'(full), int'(m_stack.size() == DEPTH));
    check("model_ovf", int'(ovf), int'(m_ovf));
    check("model_unf", int'(unf), int'(m_unf));
  endtask

  typedef struct {
    bit rst_n;
    logic [5:0] c;
    logic [WIDTH-1:0] off;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] e_pc;
    int e_lvl;
    bit e_empty;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [WIDTH-1:0] s_pc;
    int s_lvl;
    bit s_ovf, s_unf;
    logic [WIDTH-1:0] exp_ret[4];

    reset = 1'b0; {ret, call, jmp, sub, add, inc} = C_NONE;
    offset = '0; target = '0;
    m_pc = '0; m_ovf = 0; m_unf = 0;

    //          rst  cmd     off      tgt      e_pc     lvl empty
    tbl[0]  = '{1'b0, C_INC,  16'h0000, 16'h0000, 16'h0000, 0, 1'b1};
    tbl[1]  = '{1'b1, C_INC,  16'h0000, 16'h0000, 16'h0001, 0, 1'b1};
    tbl[2]  = '{1'b1, C_INC,  16'h0000, 16'h0000, 16'h0002, 0, 1'b1};
    tbl[3]  = '{1'b1, C_INC,  16'h0000, 16'h0000, 16'h0003, 0, 1'b1};
    tbl[4]  = '{1'b1, C_ADD,  16'h0010, 16'h0000, 16'h0013, 0, 1'b1};
    tbl[5]  = '{1'b1, C_SUB,  16'h0014, 16'h0000, 16'hFFFF, 0, 1'b1};
    tbl[6]  = '{1'b1, C_INC,  16'h0000, 16'h0000, 16'h0000, 0, 1'b1};
    tbl[7]  = '{1'b1, C_JMP,  16'h1234, 16'h0100, 16'h0100, 0, 1'b1};
    tbl[8]  = '{1'b1, C_CALL, 16'h0000, 16'h2000, 16'h2000, 1, 1'b0};
    tbl[9]  = '{1'b1, C_CALL, 16'h0000, 16'h3000, 16'h3000, 2, 1'b0};
    tbl[10] = '{1'b1, C_RET,  16'h5555, 16'hAAAA, 16'h2001, 1, 1'b0};
    tbl[11] = '{1'b1, C_RET,  16'h0000, 16'h0000, 16'h0101, 0, 1'b1};
    tbl[12] = '{1'b1, C_NONE, 16'hBEEF, 16'hCAFE, 16'h0101, 0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].c, tbl[i].off, tbl[i].tgt);
      check($sformatf("tbl%0d_pc", i), int'(pc), int'(tbl[i].e_pc));
      check($sformatf("tbl%0d_level", i), int'(level), tbl[i].e_lvl);
      check($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].e_empty));
    end

    // Overflow then drain: five calls into a depth-4 stack.
    drive(1'b0, C_NONE, '0, '0);
    drive(1'b1, C_JMP, '0, 16'h0010);
    for (int i = 2; i <= 6; i++) drive(1'b1, C_CALL, '0, WIDTH'(i * 16));
    check("ovf_full", int'(full), 1);
    check("ovf_flag", int'(ovf), 1);
    check("ovf_level", int'(level), 4);
    exp_ret[0] = 16'h0051; exp_ret[1] = 16'h0041;
    exp_ret[2] = 16'h0031; exp_ret[3] = 16'h0021;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, C_RET, '0, '0);
      check($sformatf("drain%0d_pc", i), int'(pc), int'(exp_ret[i]));
    end
    drive(1'b1, C_RET, '0, '0);
    check("unf_pc_held", int'(pc), 16'h0021);
    check("unf_flag", int'(unf), 1);
    check("unf_ovf_sticky", int'(ovf), 1);

    // All commands high with one entry 0x0A00: only ret applies.
    drive(1'b0, C_NONE, '0, '0);
    drive(1'b1, C_JMP, '0, 16'h09FF);
    drive(1'b1, C_CALL, '0, 16'h1234);
    drive(1'b1, C_RET | C_CALL | C_JMP | C_ADD | C_INC, 16'h0077, 16'h4444);
    check("prio_pc", int'(pc), 16'h0A00);
    check("prio_level", int'(level), 0);

    // Reset in the middle of nested calls discards the stack.
    drive(1'b1, C_CALL, '0, 16'h0300);
    drive(1'b1, C_CALL, '0, 16'h0400);
    drive(1'b0, C_CALL, '0, 16'h0500);
    check("rst_pc", int'(pc), 0);
    check("rst_level", int'(level), 0);
    check("rst_flags", int'({ovf, unf}), 0);
    drive(1'b1, C_RET, '0, '0);
    check("rst_ret_pc", int'(pc), 0);
    check("rst_ret_unf", int'(unf), 1);

    // Idle with toggling operands holds everything.
    drive(1'b1, C_CALL, '0, 16'h0777);
    s_pc = m_pc; s_lvl = m_stack.size(); s_ovf = m_ovf; s_unf = m_unf;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, C_NONE, WIDTH'($urandom), WIDTH'($urandom));
      check("idle_pc", int'(pc), int'(s_pc));
      check("idle_level", int'(level), s_lvl);
      check("idle_flags", int'({ovf, unf}), int'({s_ovf, s_unf}));
    end

    // Randomised commands against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] c;
      for (int b = 0; b < 6; b++) c[b] = ($urandom_range(3) == 0);
      drive($urandom_range(63) != 0, c, WIDTH'($urandom), WIDTH'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
